// File: rtl/interp_pkg.sv
// Shared types and constants for the interpolator pixel feeder.
// Line geometry: 8 replicated leading samples, 16 body samples, 5 replicated trailing samples.
package interp_pkg;

  localparam int DATA_W     = 32;
  localparam int PRE_PAD    = 8;
  localparam int POST_PAD   = 5;
  localparam int LINE_BEATS = PRE_PAD + 16 + POST_PAD;
  localparam int TAP_OFFSET = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } feeder_state_t;

  // Population count of up to four outstanding-read flags.
  function automatic logic [2:0] ones4(input logic [3:0] v);
    ones4 = 3'({2'b00, v[0]}) + 3'({2'b00, v[1]}) + 3'({2'b00, v[2]}) + 3'({2'b00, v[3]});
  endfunction

endpackage

// File: rtl/interp_skid_fifo.sv
// Skid FIFO of DEPTH entries behind a registered head slot.
// Entries shift toward slot 0, so the head data and valid come straight from flops.
module interp_skid_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [2:0]       count
);

  localparam int SLOTS = DEPTH + 1;

  logic [WIDTH-1:0] data_r [SLOTS];
  logic [WIDTH-1:0] data_s [SLOTS];
  logic [SLOTS-1:0] vld_r;
  logic [SLOTS-1:0] vld_s;
  logic [2:0]       cnt_r;
  logic [2:0]       cnt_s;
  logic [2:0]       wr_idx_s;

  // Next contents: shift on pop, then write the arriving sample behind the last live entry
  always_comb begin
    data_s   = data_r;
    vld_s    = vld_r;
    wr_idx_s = cnt_r;
    if (pop) begin
      for (int i = 0; i < SLOTS - 1; i++) begin
        data_s[i] = data_r[i+1];
        vld_s[i]  = vld_r[i+1];
      end
      vld_s[SLOTS-1] = 1'b0;
      wr_idx_s       = cnt_r - 3'd1;
    end else begin
      wr_idx_s = cnt_r;
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (push && (wr_idx_s == 3'(i))) begin
        data_s[i] = push_data;
        vld_s[i]  = 1'b1;
      end else begin
        vld_s[i] = vld_s[i];
      end
    end
    cnt_s = cnt_r + 3'({2'b00, push}) - 3'({2'b00, pop});
  end

  // Storage and occupancy registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) data_r[i] <= '0;
      vld_r <= '0;
      cnt_r <= 3'd0;
    end else begin
      data_r <= data_s;
      vld_r  <= vld_s;
      cnt_r  <= cnt_s;
    end
  end

  assign head_data  = data_r[0];
  assign head_valid = vld_r[0];
  assign count      = cnt_r;

endmodule

// File: rtl/interp_pixel_feeder.sv
// Read-side sequencer for the 8-tap interpolator: fetches a block line by line with
// edge replication and streams it through a skid FIFO, flagging valid tap windows.
module interp_pixel_feeder
  import interp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int BLK_W   = 16,
  parameter int BLK_H   = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid,
  input  logic              ready,
  output logic              tap_valid,
  output logic [3:0]        tap_pos,
  output logic [3:0]        line_idx,
  output logic              busy,
  output logic              done
);

  // Every issued read owns a storage slot until it leaves: head slot plus MEM_LAT+1 skid entries.
  localparam int CAP = MEM_LAT + 2;

  feeder_state_t      state_r, state_s;
  logic               mode_r;
  logic [ADDR_W-1:0]  base_r;
  logic [3:0]         rd_line_r;
  logic [4:0]         rd_k_r;
  logic               rd_en_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [ADDR_W-1:0]  addr_s;
  logic [3:0]         col_s;
  logic [MEM_LAT-1:0] lat_sr_r;
  logic [2:0]         fifo_cnt_s;
  logic [2:0]         inflight_s;
  logic [3:0]         credit_s;
  logic               pop_s, push_s, issue_s, last_issue_s, drained_s, accept_s;
  logic [4:0]         beat_r;
  logic [3:0]         out_line_r;
  logic               tap_valid_r, busy_r, done_r;
  logic [3:0]         tap_pos_r, line_idx_r;

  function automatic logic [3:0] clamp_col(input logic [4:0] k);
    if (k < 5'(PRE_PAD))              clamp_col = 4'd0;
    else if (k >= 5'(PRE_PAD + BLK_W)) clamp_col = 4'(BLK_W - 1);
    else                               clamp_col = 4'(k - 5'(PRE_PAD));
  endfunction

  assign pop_s      = pix_valid & ready;
  assign push_s     = lat_sr_r[MEM_LAT-1];
  assign accept_s   = (state_r == IDLE) && start;
  assign inflight_s = ones4(4'({lat_sr_r, rd_en_r}));
  // Occupancy after this edge if nothing new is issued; pop frees a slot in the same cycle.
  assign credit_s   = {1'b0, fifo_cnt_s} - {3'b000, pop_s} + {1'b0, inflight_s};

  // Next state and read-issue decision
  always_comb begin
    state_s      = state_r;
    issue_s      = 1'b0;
    last_issue_s = 1'b0;
    drained_s    = (credit_s == 4'd0);
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        issue_s      = (credit_s < 4'(CAP));
        last_issue_s = issue_s && (rd_line_r == 4'(BLK_H - 1)) && (rd_k_r == 5'(LINE_BEATS - 1));
        if (last_issue_s) state_s = DRAIN;
        else              state_s = RUN;
      end
      DRAIN: begin
        if (drained_s) state_s = IDLE;
        else           state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // Address of the current read: rows walk columns in mode 0, columns walk rows in mode 1
  always_comb begin
    col_s = clamp_col(rd_k_r);
    if (mode_r) addr_s = base_r + (ADDR_W'(col_s) * ADDR_W'(BLK_W)) + ADDR_W'(rd_line_r);
    else        addr_s = base_r + (ADDR_W'(rd_line_r) * ADDR_W'(BLK_W)) + ADDR_W'(col_s);
  end

  // Control state, latched pass parameters, read counters and in-flight tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      mode_r    <= 1'b0;
      base_r    <= '0;
      rd_line_r <= 4'd0;
      rd_k_r    <= 5'd0;
      rd_en_r   <= 1'b0;
      addr_r    <= '0;
      lat_sr_r  <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        mode_r    <= mode;
        base_r    <= base_addr;
        rd_line_r <= 4'd0;
        rd_k_r    <= 5'd0;
      end else if (issue_s) begin
        if (rd_k_r == 5'(LINE_BEATS - 1)) begin
          rd_k_r    <= 5'd0;
          rd_line_r <= rd_line_r + 4'd1;
        end else begin
          rd_k_r <= rd_k_r + 5'd1;
        end
      end
      rd_en_r <= issue_s;
      if (issue_s) addr_r <= addr_s;
      lat_sr_r[0] <= rd_en_r;
      for (int i = 1; i < MEM_LAT; i++) lat_sr_r[i] <= lat_sr_r[i-1];
      busy_r <= (state_s != IDLE);
      done_r <= (state_r == DRAIN) && drained_s;
    end
  end

  // Output-side beat counting and tap-window flags
  always_ff @(posedge clock) begin
    if (reset) begin
      beat_r      <= 5'd0;
      out_line_r  <= 4'd0;
      tap_valid_r <= 1'b0;
      tap_pos_r   <= 4'd0;
      line_idx_r  <= 4'd0;
    end else begin
      if (accept_s) begin
        beat_r     <= 5'd0;
        out_line_r <= 4'd0;
      end else if (pop_s) begin
        if (beat_r == 5'(LINE_BEATS - 1)) begin
          beat_r     <= 5'd0;
          out_line_r <= out_line_r + 4'd1;
        end else begin
          beat_r <= beat_r + 5'd1;
        end
      end
      tap_valid_r <= pop_s && (beat_r >= 5'(TAP_OFFSET)) && (beat_r < 5'(TAP_OFFSET + BLK_W));
      if (pop_s) line_idx_r <= out_line_r;
      if (pop_s && (beat_r >= 5'(TAP_OFFSET)) && (beat_r < 5'(TAP_OFFSET + BLK_W)))
        tap_pos_r <= 4'(beat_r - 5'(TAP_OFFSET));
    end
  end

  interp_skid_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (MEM_LAT + 1)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push_s),
    .push_data  (mem_rdata),
    .pop        (pop_s),
    .head_data  (pix_out),
    .head_valid (pix_valid),
    .count      (fifo_cnt_s)
  );

  assign mem_rd_en = rd_en_r;
  assign mem_addr  = addr_r;
  assign tap_valid = tap_valid_r;
  assign tap_pos   = tap_pos_r;
  assign line_idx  = line_idx_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_interp_pixel_feeder.sv
// Bench for interp_pixel_feeder: memory returns its own address; every beat, tap flag and
// done pulse is compared against a block-level model of the edge-replicated line sequence.
module tb_interp_pixel_feeder;

  localparam int MEM_LAT = 1;
  localparam int BEATS   = 464;

  logic        clock = 1'b0;
  logic        reset, start, mode, ready;
  logic [31:0] base_addr, mem_addr, mem_rdata, pix_out;
  logic        mem_rd_en, pix_valid, tap_valid, busy, done;
  logic [3:0]  tap_pos, line_idx;
  logic [31:0] rq [MEM_LAT];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clock = ~clock;

  // Fixed-latency memory whose contents equal the address
  always @(posedge clock) begin
    rq[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) rq[i] <= rq[i-1];
  end
  assign mem_rdata = rq[MEM_LAT-1];

  interp_pixel_feeder #(.ADDR_W(32), .BLK_W(16), .BLK_H(16), .MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pix_out(pix_out), .pix_valid(pix_valid), .ready(ready),
    .tap_valid(tap_valid), .tap_pos(tap_pos), .line_idx(line_idx),
    .busy(busy), .done(done)
  );

  // Beat b of a block: line b/29, read index (b%29)-8 clamped into 0..15
  function automatic logic [31:0] exp_pix(input logic m, input logic [31:0] base, input int b);
    int line, k, c;
    line = b / 29;
    k    = (b % 29) - 8;
    c    = (k < 0) ? 0 : ((k > 15) ? 15 : k);
    return m ? base + 32'(c * 16 + line) : base + 32'(line * 16 + c);
  endfunction

  // One block pass; rmode 0 = ready high, 1 = toggling, 2 = random
  task automatic run_pass(input logic m, input logic [31:0] base, input int rmode,
                          input bit launch, input bit chain, input bit poke);
    int cyc, beat, taps, dones, done_cyc, first_cyc, tail;
    logic prev_stall;
    logic [31:0] prev_pix;
    beat = 0; taps = 0; dones = 0; done_cyc = -1; first_cyc = -1; tail = -1;
    prev_stall = 1'b0; prev_pix = 32'd0;
    if (launch) begin
      @(negedge clock);
      start = 1'b1; mode = m; base_addr = base;
      @(negedge clock);
      start = 1'b0; mode = 1'($urandom); base_addr = $urandom;
    end
    cyc = 0;
    while (cyc < 3000 && tail != 0) begin
      start = 1'b0;
      if (poke && cyc == 60) begin start = 1'b1; base_addr = 32'hDEAD0000; end
      if (prev_stall) begin
        n_checks++;
        if (pix_valid !== 1'b1 || pix_out !== prev_pix)
          $display("FAIL stall_hold cyc=%0d got valid=%b pix=%h want valid=1 pix=%h", cyc, pix_valid, pix_out, prev_pix);
        if (pix_valid !== 1'b1 || pix_out !== prev_pix) n_errors++;
      end
      if (tap_valid) begin
        n_checks++;
        if (taps >= 256 || tap_pos !== 4'(taps % 16) || line_idx !== 4'(taps / 16)) begin
          n_errors++;
          $display("FAIL tap #%0d got pos=%0d line=%0d want pos=%0d line=%0d", taps, tap_pos, line_idx, taps % 16, taps / 16);
        end
        taps++;
      end
      if (pix_valid && first_cyc < 0) first_cyc = cyc;
      if (done) begin dones++; if (done_cyc < 0) done_cyc = cyc; end
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 2 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (pix_valid && ready) begin
        n_checks++;
        if (beat >= BEATS || pix_out !== exp_pix(m, base, beat)) begin
          n_errors++;
          $display("FAIL beat %0d got %h want %h", beat, pix_out, exp_pix(m, base, beat));
        end
        beat++;
      end
      prev_stall = pix_valid && !ready;
      prev_pix   = pix_out;
      if (done && chain) begin start = 1'b1; mode = m; base_addr = base; break; end
      if (tail > 0) tail--;
      else if (done && tail < 0) tail = 3;
      @(negedge clock);
      cyc++;
    end
    n_checks++;
    if (beat != BEATS || taps != 256 || dones != 1) begin
      n_errors++;
      $display("FAIL pass_totals got beats=%0d taps=%0d dones=%0d want 464 256 1", beat, taps, dones);
    end
    if (rmode == 0) begin
      n_checks++;
      if (first_cyc != 2 + MEM_LAT || done_cyc != 2 + MEM_LAT + BEATS) begin
        n_errors++;
        $display("FAIL pass_timing got first=%0d done=%0d want %0d %0d", first_cyc, done_cyc, 2 + MEM_LAT, 2 + MEM_LAT + BEATS);
      end
    end
    if (!chain) begin
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy got %b want 0", busy); end
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({mem_rd_en, mem_addr, pix_out, pix_valid, tap_valid, tap_pos, line_idx, busy, done} !== '0) begin
      n_errors++;
      $display("FAIL %s got rd=%b addr=%h pix=%h pv=%b tv=%b pos=%0d line=%0d busy=%b done=%b want all 0",
               tag, mem_rd_en, mem_addr, pix_out, pix_valid, tap_valid, tap_pos, line_idx, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 1'b0; ready = 1'b0; base_addr = 32'd0;
    repeat (3) @(negedge clock);
    check_all_zero("reset_hold");
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("reset_release");
  endtask

  task automatic test_row_pass();      run_pass(1'b0, 32'h0, 0, 1'b1, 1'b0, 1'b0); endtask
  task automatic test_column_pass();   run_pass(1'b1, 32'h100, 0, 1'b1, 1'b0, 1'b0); endtask
  task automatic test_stall_toggle();  run_pass(1'b0, 32'h0, 1, 1'b1, 1'b0, 1'b0); endtask
  task automatic test_addr_wrap();     run_pass(1'b1, 32'hFFFFFF80, 0, 1'b1, 1'b0, 1'b0); endtask
  task automatic test_start_ignored(); run_pass(1'b0, 32'h40, 0, 1'b1, 1'b0, 1'b1); endtask

  task automatic test_random_ready();
    for (int i = 0; i < 3; i++) run_pass(1'($urandom), $urandom, 2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_pass(1'b0, 32'h1000, 0, 1'b1, 1'b1, 1'b0);
    @(negedge clock);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy got %b want 1", busy); end
    run_pass(1'b0, 32'h1000, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int cnt, guard;
    cnt = 0; guard = 0;
    @(negedge clock);
    start = 1'b1; mode = 1'b0; base_addr = 32'h0; ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (cnt < 100 && guard < 1000) begin
      if (pix_valid && ready) cnt++;
      @(negedge clock);
      guard++;
    end
    n_checks++;
    if (cnt != 100) begin n_errors++; $display("FAIL mid_reach got %0d want 100", cnt); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_all_zero("mid_reset");
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      n_checks++;
      if (pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_errors++;
        $display("FAIL post_reset cyc=%0d got pv=%b busy=%b done=%b want 0 0 0", i, pix_valid, busy, done);
      end
    end
    run_pass(1'b0, 32'h0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_row_pass();
    test_column_pass();
    test_stall_toggle();
    test_random_ready();
    test_addr_wrap();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
